ip_tx_noc_in: RTL and testbench

- NoC-side receiver at the IP TX tile. It consumes the flit stream that the UDP TX tile emits toward IP_TX_TILE_X/Y: one header flit, then ceil(len/64) payload flits.
- It splits that stream into a metadata handshake (src/dst IP, payload length, protocol, timestamp) and a MAC-width data stream with last/padbytes.
- Its outputs feed the IP header assembler.

---
 rtl/ip_tx_tile_pkg.sv | 52 +++++
 rtl/ip_tx_noc_in_if.sv | 48 ++++
 rtl/ip_tx_noc_in_ctrl.sv | 83 ++++++++
 rtl/ip_tx_noc_in.sv | 125 ++++++++++++
 tb/tb_ip_tx_noc_in.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ip_tx_tile_pkg.sv
// Shared types and widths for the IP TX tile: NoC header flit layout, receiver FSM
// states, and helpers that turn a byte length into flit count and trailing pad bytes.
package ip_tx_tile_pkg;

  localparam int unsigned NOC_DATA_WIDTH  = 512;
  localparam int unsigned XY_W            = 8;
  localparam int unsigned MSG_LEN_W       = 22;
  localparam int unsigned MSG_TYPE_W      = 8;
  localparam int unsigned IP_ADDR_W       = 32;
  localparam int unsigned TOT_LEN_W       = 16;
  localparam int unsigned PROTOCOL_W      = 8;
  localparam int unsigned MSG_TIMESTAMP_W = 64;
  localparam int unsigned MAC_INTERFACE_W = 512;
  localparam int unsigned MAC_PADBYTES_W  = 6;
  localparam int unsigned MAC_BYTES       = 64;
  // 65535 bytes needs 1024 flits, one more than 10 bits can count
  localparam int unsigned FLIT_CNT_W      = 11;

  localparam int unsigned HDR_USED_W = 4 * XY_W + MSG_LEN_W + MSG_TYPE_W + 2 * IP_ADDR_W
                                     + TOT_LEN_W + PROTOCOL_W + MSG_TIMESTAMP_W;
  localparam int unsigned HDR_PAD_W  = NOC_DATA_WIDTH - HDR_USED_W;

  typedef struct packed {
    logic [XY_W-1:0]            dst_x;
    logic [XY_W-1:0]            dst_y;
    logic [XY_W-1:0]            src_x;
    logic [XY_W-1:0]            src_y;
    logic [MSG_LEN_W-1:0]       msg_len;
    logic [MSG_TYPE_W-1:0]      msg_type;
    logic [IP_ADDR_W-1:0]       src_ip;
    logic [IP_ADDR_W-1:0]       dst_ip;
    logic [TOT_LEN_W-1:0]       data_len;
    logic [PROTOCOL_W-1:0]      protocol;
    logic [MSG_TIMESTAMP_W-1:0] timestamp;
    logic [HDR_PAD_W-1:0]       padding;
  } udp_tx_noc_hdr_flit;

  typedef enum logic [1:0] {
    WAIT_HDR = 2'd0,
    HDR_OUT  = 2'd1,
    DATA     = 2'd2
  } noc_in_state_e;

  function automatic logic [FLIT_CNT_W-1:0] flits_for_len(input logic [TOT_LEN_W-1:0] len);
    return FLIT_CNT_W'((32'(len) + MAC_BYTES - 1) / MAC_BYTES);
  endfunction

  function automatic logic [MAC_PADBYTES_W-1:0] pad_for_len(input logic [TOT_LEN_W-1:0] len);
    return MAC_PADBYTES_W'(MAC_BYTES - 32'(len[MAC_PADBYTES_W-1:0]));
  endfunction

endpackage

// File: rtl/ip_tx_noc_in_if.sv
// Bus bundle for ip_tx_noc_in: NoC flit input plus metadata and payload outputs
// toward the IP header assembler.
interface ip_tx_noc_in_if;
  import ip_tx_tile_pkg::*;

  logic                       noc0_ctovr_ip_tx_in_val;
  logic [NOC_DATA_WIDTH-1:0]  noc0_ctovr_ip_tx_in_data;
  logic                       ip_tx_in_noc0_ctovr_rdy;

  logic                       ip_tx_in_assemble_hdr_val;
  logic [IP_ADDR_W-1:0]       ip_tx_in_assemble_src_ip;
  logic [IP_ADDR_W-1:0]       ip_tx_in_assemble_dst_ip;
  logic [TOT_LEN_W-1:0]       ip_tx_in_assemble_data_len;
  logic [PROTOCOL_W-1:0]      ip_tx_in_assemble_protocol;
  logic [MSG_TIMESTAMP_W-1:0] ip_tx_in_assemble_timestamp;
  logic                       assemble_ip_tx_in_hdr_rdy;

  logic                       ip_tx_in_assemble_data_val;
  logic [MAC_INTERFACE_W-1:0] ip_tx_in_assemble_data;
  logic                       ip_tx_in_assemble_last;
  logic [MAC_PADBYTES_W-1:0]  ip_tx_in_assemble_padbytes;
  logic                       assemble_ip_tx_in_data_rdy;

  logic                       ip_tx_in_len_err;

  // receiver side
  modport slave (
    input  noc0_ctovr_ip_tx_in_val, noc0_ctovr_ip_tx_in_data,
    input  assemble_ip_tx_in_hdr_rdy, assemble_ip_tx_in_data_rdy,
    output ip_tx_in_noc0_ctovr_rdy,
    output ip_tx_in_assemble_hdr_val, ip_tx_in_assemble_src_ip, ip_tx_in_assemble_dst_ip,
    output ip_tx_in_assemble_data_len, ip_tx_in_assemble_protocol, ip_tx_in_assemble_timestamp,
    output ip_tx_in_assemble_data_val, ip_tx_in_assemble_data, ip_tx_in_assemble_last,
    output ip_tx_in_assemble_padbytes, ip_tx_in_len_err
  );

  // environment side: flit source plus assembler sink
  modport master (
    output noc0_ctovr_ip_tx_in_val, noc0_ctovr_ip_tx_in_data,
    output assemble_ip_tx_in_hdr_rdy, assemble_ip_tx_in_data_rdy,
    input  ip_tx_in_noc0_ctovr_rdy,
    input  ip_tx_in_assemble_hdr_val, ip_tx_in_assemble_src_ip, ip_tx_in_assemble_dst_ip,
    input  ip_tx_in_assemble_data_len, ip_tx_in_assemble_protocol, ip_tx_in_assemble_timestamp,
    input  ip_tx_in_assemble_data_val, ip_tx_in_assemble_data, ip_tx_in_assemble_last,
    input  ip_tx_in_assemble_padbytes, ip_tx_in_len_err
  );

endinterface

// File: rtl/ip_tx_noc_in_ctrl.sv
// Receiver control: header/metadata/data FSM, remaining-flit counter and the
// handshake steering between the NoC port and the assembler.
module ip_tx_noc_in_ctrl
  import ip_tx_tile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flit_val,
  input  logic                  hdr_rdy,
  input  logic                  data_rdy,
  input  logic [FLIT_CNT_W-1:0] init_cnt,
  output logic                  flit_rdy_c,
  output logic                  capture_c,
  output logic                  hdr_val_c,
  output logic                  data_val_c,
  output logic                  last_c
);

  noc_in_state_e         state_q, state_d;
  logic [FLIT_CNT_W-1:0] flits_left_q, flits_left_d;

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_HDR;
      flits_left_q <= '0;
    end else begin
      state_q      <= state_d;
      flits_left_q <= flits_left_d;
    end
  end

  // next state and counter update
  always_comb begin
    state_d      = state_q;
    flits_left_d = flits_left_q;
    case (state_q)
      WAIT_HDR: begin
        if (flit_val) begin
          flits_left_d = init_cnt;
          state_d      = HDR_OUT;
        end
      end
      HDR_OUT: begin
        if (hdr_rdy) begin
          state_d = (flits_left_q != '0) ? DATA : WAIT_HDR;
        end
      end
      DATA: begin
        if (flit_val && data_rdy) begin
          flits_left_d = flits_left_q - FLIT_CNT_W'(1);
          if (flits_left_q == FLIT_CNT_W'(1)) begin
            state_d = WAIT_HDR;
          end
        end
      end
      default: state_d = WAIT_HDR;
    endcase
  end

  // handshake outputs; payload beats pass straight through in DATA
  always_comb begin
    flit_rdy_c = 1'b0;
    capture_c  = 1'b0;
    hdr_val_c  = 1'b0;
    data_val_c = 1'b0;
    last_c     = 1'b0;
    case (state_q)
      WAIT_HDR: begin
        flit_rdy_c = 1'b1;
        capture_c  = flit_val;
      end
      HDR_OUT: hdr_val_c = 1'b1;
      DATA: begin
        flit_rdy_c = data_rdy;
        data_val_c = flit_val;
        last_c     = (flits_left_q == FLIT_CNT_W'(1));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ip_tx_noc_in.sv
// NoC receiver at the IP TX tile: splits header flit + payload flits into a metadata
// handshake and a MAC-width data stream. Optional IP_TX_NOC_IN_LEN_CHK_EN cross-checks msg_len.
module ip_tx_noc_in
  import ip_tx_tile_pkg::*;
#(
  parameter int SRC_X = -1,
  parameter int SRC_Y = -1
) (
  input  logic           clk,
  input  logic           rst_n,
  ip_tx_noc_in_if.slave  bus
);

  udp_tx_noc_hdr_flit hdr_flit;
  logic [FLIT_CNT_W-1:0] len_cnt;
  logic [FLIT_CNT_W-1:0] init_cnt;
  logic capture_c, flit_rdy_c, hdr_val_c, data_val_c, last_c;

  logic [IP_ADDR_W-1:0]       src_ip_q, src_ip_d;
  logic [IP_ADDR_W-1:0]       dst_ip_q, dst_ip_d;
  logic [TOT_LEN_W-1:0]       data_len_q, data_len_d;
  logic [PROTOCOL_W-1:0]      protocol_q, protocol_d;
  logic [MSG_TIMESTAMP_W-1:0] timestamp_q, timestamp_d;
  logic                       hdr_unused;

  assign hdr_flit = bus.noc0_ctovr_ip_tx_in_data;
  assign len_cnt  = flits_for_len(hdr_flit.data_len);

`ifdef IP_TX_NOC_IN_LEN_CHK_EN
  logic len_err_q, len_err_d;

  assign init_cnt   = FLIT_CNT_W'(hdr_flit.msg_len);
  assign hdr_unused = ^{hdr_flit.src_x, hdr_flit.src_y, hdr_flit.msg_type, hdr_flit.padding};

  // sticky flag: header flit count disagrees with the byte length
  always_comb begin
    len_err_d = len_err_q;
    if (capture_c && (hdr_flit.msg_len != MSG_LEN_W'(len_cnt))) begin
      len_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) len_err_q <= 1'b0;
    else        len_err_q <= len_err_d;
  end

  assign bus.ip_tx_in_len_err = len_err_q;
`else
  assign init_cnt   = len_cnt;
  assign hdr_unused = ^{hdr_flit.src_x, hdr_flit.src_y, hdr_flit.msg_type, hdr_flit.padding,
                        hdr_flit.msg_len};
  assign bus.ip_tx_in_len_err = 1'b0;
`endif

  ip_tx_noc_in_ctrl u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .flit_val   (bus.noc0_ctovr_ip_tx_in_val),
    .hdr_rdy    (bus.assemble_ip_tx_in_hdr_rdy),
    .data_rdy   (bus.assemble_ip_tx_in_data_rdy),
    .init_cnt   (init_cnt),
    .flit_rdy_c (flit_rdy_c),
    .capture_c  (capture_c),
    .hdr_val_c  (hdr_val_c),
    .data_val_c (data_val_c),
    .last_c     (last_c)
  );

  // metadata capture from the header flit
  always_comb begin
    src_ip_d    = src_ip_q;
    dst_ip_d    = dst_ip_q;
    data_len_d  = data_len_q;
    protocol_d  = protocol_q;
    timestamp_d = timestamp_q;
    if (capture_c) begin
      src_ip_d    = hdr_flit.src_ip;
      dst_ip_d    = hdr_flit.dst_ip;
      data_len_d  = hdr_flit.data_len;
      protocol_d  = hdr_flit.protocol;
      timestamp_d = hdr_flit.timestamp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      data_len_q  <= '0;
      protocol_q  <= '0;
      timestamp_q <= '0;
    end else begin
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      data_len_q  <= data_len_d;
      protocol_q  <= protocol_d;
      timestamp_q <= timestamp_d;
    end
  end

  assign bus.ip_tx_in_noc0_ctovr_rdy     = flit_rdy_c;
  assign bus.ip_tx_in_assemble_hdr_val   = hdr_val_c;
  assign bus.ip_tx_in_assemble_src_ip    = src_ip_q;
  assign bus.ip_tx_in_assemble_dst_ip    = dst_ip_q;
  assign bus.ip_tx_in_assemble_data_len  = data_len_q;
  assign bus.ip_tx_in_assemble_protocol  = protocol_q;
  assign bus.ip_tx_in_assemble_timestamp = timestamp_q;
  assign bus.ip_tx_in_assemble_data_val  = data_val_c;
  assign bus.ip_tx_in_assemble_data      = MAC_INTERFACE_W'(bus.noc0_ctovr_ip_tx_in_data);
  assign bus.ip_tx_in_assemble_last      = last_c;
  assign bus.ip_tx_in_assemble_padbytes  = last_c ? pad_for_len(data_len_q) : '0;

`ifndef SYNTHESIS
  // misrouted packets are still consumed, but flag them in simulation
  always_ff @(posedge clk) begin
    if (rst_n && capture_c) begin
      assert ((hdr_flit.dst_x == XY_W'(SRC_X)) && (hdr_flit.dst_y == XY_W'(SRC_Y)))
        else $error("ip_tx_noc_in: header flit routed to (%0d,%0d), tile is (%0d,%0d)",
                    hdr_flit.dst_x, hdr_flit.dst_y, SRC_X, SRC_Y);
    end
  end
`endif

endmodule

// File: tb/tb_ip_tx_noc_in.sv
// Self-checking bench for ip_tx_noc_in: directed boundary packets plus randomized
// traffic checked against a packet-level expectation model.
module tb_ip_tx_noc_in;
  import ip_tx_tile_pkg::*;

  localparam int TB_X = 3;
  localparam int TB_Y = 2;
  localparam int META_W = 2 * IP_ADDR_W + TOT_LEN_W + PROTOCOL_W + MSG_TIMESTAMP_W;

  typedef struct {
    logic [META_W-1:0] meta;
    int                nbeats;
    bit                len_mis;
  } exp_hdr_t;

  typedef struct {
    logic [MAC_INTERFACE_W-1:0] data;
    bit                         last;
    logic [MAC_PADBYTES_W-1:0]  pad;
  } exp_beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ip_tx_noc_in_if bus ();

  ip_tx_noc_in #(.SRC_X(TB_X), .SRC_Y(TB_Y)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NOC_DATA_WIDTH-1:0] flit_q[$];
  exp_hdr_t  exp_hdr_q[$];
  exp_beat_t exp_beat_q[$];
  bit  hdr_pending = 1'b0;
  int  cur_left = 0;
  bit  exp_len_err = 1'b0;

  int  val_pct = 100, hrdy_pct = 100, drdy_pct = 100;
  int  hold_cnt = 0;
  bit  drdy_toggle = 1'b0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // queue one packet: header flit, payload flits and everything the assembler should see
  task automatic add_pkt(input int len, input int mlen);
    udp_tx_noc_hdr_flit h;
    exp_hdr_t  eh;
    exp_beat_t eb;
    int ceil_n, n;
    h = '0;
    h.dst_x     = XY_W'(TB_X);
    h.dst_y     = XY_W'(TB_Y);
    h.src_x     = XY_W'($urandom_range(0, 7));
    h.src_y     = XY_W'($urandom_range(0, 7));
    h.msg_len   = MSG_LEN_W'(mlen);
    h.msg_type  = MSG_TYPE_W'($urandom());
    h.src_ip    = $urandom();
    h.dst_ip    = $urandom();
    h.data_len  = TOT_LEN_W'(len);
    h.protocol  = PROTOCOL_W'($urandom());
    h.timestamp = {$urandom(), $urandom()};
    ceil_n = (len + 63) / 64;
`ifdef IP_TX_NOC_IN_LEN_CHK_EN
    n = mlen;
    eh.len_mis = (mlen != ceil_n);
`else
    n = ceil_n;
    eh.len_mis = 1'b0;
`endif
    eh.meta   = {h.src_ip, h.dst_ip, h.data_len, h.protocol, h.timestamp};
    eh.nbeats = n;
    exp_hdr_q.push_back(eh);
    flit_q.push_back(h);
    for (int i = 1; i <= n; i++) begin
      eb.data = rand512();
      eb.last = (i == n);
      eb.pad  = (i == n) ? MAC_PADBYTES_W'((64 - len % 64) % 64) : '0;
      exp_beat_q.push_back(eb);
      flit_q.push_back(eb.data);
    end
  endtask

  // one clock: drive inputs after the edge, observe and score at the falling edge
  task automatic step();
    logic fv, fr;
    exp_beat_t eb;
    @(posedge clk);
    #1;
    bus.noc0_ctovr_ip_tx_in_val  = (flit_q.size() > 0) && ($urandom_range(99) < val_pct);
    bus.noc0_ctovr_ip_tx_in_data = (flit_q.size() > 0) ? flit_q[0] : rand512();
    bus.assemble_ip_tx_in_hdr_rdy = (hold_cnt > 0) ? 1'b0 : ($urandom_range(99) < hrdy_pct);
    bus.assemble_ip_tx_in_data_rdy = drdy_toggle ? ~bus.assemble_ip_tx_in_data_rdy
                                                 : ($urandom_range(99) < drdy_pct);
    @(negedge clk);
    fv = bus.noc0_ctovr_ip_tx_in_val;
    fr = bus.ip_tx_in_noc0_ctovr_rdy;
    if (hdr_pending) begin
      check("hdr_val", bus.ip_tx_in_assemble_hdr_val, 1'b1);
      check("hdr_phase_flit_rdy", fr, 1'b0);
      check("hdr_phase_data_val", bus.ip_tx_in_assemble_data_val, 1'b0);
      if (exp_hdr_q.size() > 0)
        check("meta", {bus.ip_tx_in_assemble_src_ip, bus.ip_tx_in_assemble_dst_ip,
                       bus.ip_tx_in_assemble_data_len, bus.ip_tx_in_assemble_protocol,
                       bus.ip_tx_in_assemble_timestamp}, exp_hdr_q[0].meta);
      if (hold_cnt > 0) hold_cnt--;
      if (bus.assemble_ip_tx_in_hdr_rdy && exp_hdr_q.size() > 0) begin
        cur_left = exp_hdr_q[0].nbeats;
        void'(exp_hdr_q.pop_front());
        hdr_pending = 1'b0;
      end
    end else if (cur_left > 0) begin
      check("data_val_passthru", bus.ip_tx_in_assemble_data_val, fv);
      check("data_flit_rdy", fr, bus.assemble_ip_tx_in_data_rdy);
      check("data_phase_hdr_val", bus.ip_tx_in_assemble_hdr_val, 1'b0);
      if (fv && bus.assemble_ip_tx_in_data_rdy) begin
        eb = exp_beat_q.pop_front();
        check("beat_data", bus.ip_tx_in_assemble_data, eb.data);
        check("beat_last", bus.ip_tx_in_assemble_last, eb.last);
        check("beat_padbytes", bus.ip_tx_in_assemble_padbytes, eb.pad);
        cur_left--;
      end
    end else begin
      check("idle_flit_rdy", fr, 1'b1);
      check("idle_hdr_val", bus.ip_tx_in_assemble_hdr_val, 1'b0);
      check("idle_data_val", bus.ip_tx_in_assemble_data_val, 1'b0);
      if (fv) begin
        hdr_pending = 1'b1;
        if (exp_hdr_q.size() > 0) exp_len_err |= exp_hdr_q[0].len_mis;
      end
    end
    if (fv && fr) void'(flit_q.pop_front());
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((flit_q.size() > 0 || hdr_pending || cur_left > 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain_in_budget"}, n < budget, 1'b1);
    repeat (2) step();
    check({tag, "_len_err"}, bus.ip_tx_in_len_err, exp_len_err);
  endtask

  initial begin
    bus.noc0_ctovr_ip_tx_in_val    = 1'b0;
    bus.noc0_ctovr_ip_tx_in_data   = '0;
    bus.assemble_ip_tx_in_hdr_rdy  = 1'b1;
    bus.assemble_ip_tx_in_data_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_val", bus.ip_tx_in_assemble_hdr_val, 1'b0);
    check("rst_data_val", bus.ip_tx_in_assemble_data_val, 1'b0);
    check("rst_last", bus.ip_tx_in_assemble_last, 1'b0);
    check("rst_padbytes", bus.ip_tx_in_assemble_padbytes, '0);
    check("rst_len_err", bus.ip_tx_in_len_err, 1'b0);
    check("rst_flit_rdy", bus.ip_tx_in_noc0_ctovr_rdy, 1'b1);
    check("rst_data_len", bus.ip_tx_in_assemble_data_len, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic lengths with everything ready
    add_pkt(100, 2);  drain("len100", 50);
    add_pkt(64, 1);   drain("len64", 50);
    add_pkt(0, 0);    drain("len0", 50);

    // assembler stalls the header, then throttles payload every other cycle
    hold_cnt = 5;
    drdy_toggle = 1'b1;
    add_pkt(150, 3);  drain("stall", 100);
    drdy_toggle = 1'b0;
    bus.assemble_ip_tx_in_data_rdy = 1'b1;

    // reset in the middle of a packet, after its first beat
    add_pkt(150, 3);
    for (int i = 0; i < 20 && cur_left != 2; i++) step();
    check("rst_mid_reached_beat1", cur_left, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.noc0_ctovr_ip_tx_in_val = 1'b0;
    #1;
    check("rst_mid_hdr_val", bus.ip_tx_in_assemble_hdr_val, 1'b0);
    check("rst_mid_data_val", bus.ip_tx_in_assemble_data_val, 1'b0);
    check("rst_mid_last", bus.ip_tx_in_assemble_last, 1'b0);
    check("rst_mid_flit_rdy", bus.ip_tx_in_noc0_ctovr_rdy, 1'b1);
    flit_q.delete();
    exp_hdr_q.delete();
    exp_beat_q.delete();
    hdr_pending = 1'b0;
    cur_left = 0;
    exp_len_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(100, 2);  drain("post_rst", 50);

    // msg_len disagrees with data_len, then a consistent packet: error must stick
    add_pkt(100, 3);  drain("len_chk", 50);
    add_pkt(64, 1);   drain("len_chk_sticky", 50);

    // largest UDP length
    add_pkt(65535, 1024);  drain("max_len", 3000);

    // randomized traffic with random valid and ready throttling
    val_pct = 70; hrdy_pct = 60; drdy_pct = 60;
    for (int p = 0; p < 25; p++) begin
      int len;
      len = ($urandom_range(5) == 0) ? 64 * $urandom_range(0, 5) : $urandom_range(0, 300);
      add_pkt(len, (len + 63) / 64);
    end
    drain("random", 20000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
